// File: rtl/ysyx_22041211_pc_gen_if.sv
// Fetch-side handshake between the PC generator and the instruction fetch unit.
// The PC generator drives pc/pc_valid (master); the IFU answers with pc_ready (slave).
interface ysyx_22041211_pc_gen_if #(
    parameter int ADDR_LEN = 32
);
    logic [ADDR_LEN-1:0] pc;
    logic                pc_valid;
    logic                pc_ready;

    modport master (output pc, output pc_valid, input pc_ready);
    modport slave  (input pc, input pc_valid, output pc_ready);
endinterface

// File: rtl/ysyx_22041211_pc_gen.sv
// Program-counter generator for the ysyx_22041211 core.
// Holds the fetch PC and offers it to the IFU over a valid/ready handshake.
// It steps sequentially on each accepted fetch, takes trap/branch redirects,
// supports halt and counts accepted fetches.
// Optional feature macro: YSYX_22041211_PC_ALIGN_CHECK_EN
//   defined   -> misaligned redirect targets are rejected and raise a sticky
//                pc_misalign flag that blocks fetch until an aligned redirect
//   undefined -> redirect targets are loaded with bits [1:0] cleared,
//                pc_misalign is constant 0
module ysyx_22041211_pc_gen #(
    parameter int                ADDR_LEN  = 32,
    parameter logic [ADDR_LEN-1:0] RESET_VAL = 32'h80000000,
    parameter int                STEP      = 4,
    parameter int                CNT_LEN   = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        stall,
    input  logic                        br_valid,
    input  logic [ADDR_LEN-1:0]         br_target,
    input  logic                        trap_valid,
    input  logic [ADDR_LEN-1:0]         trap_target,
    input  logic                        halt,
    ysyx_22041211_pc_gen_if.master      fetch,
    output logic [CNT_LEN-1:0]          fetch_cnt,
    output logic                        pc_misalign
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [ADDR_LEN-1:0] pc_r, pc_nxt;
    logic [CNT_LEN-1:0]  cnt_r, cnt_nxt;
    logic                mis_r;
    logic                mis_nxt;
    logic                redir;
    logic [ADDR_LEN-1:0] redir_tgt;
    logic                offer;
    logic                fire;

    // Trap redirects outrank branch redirects; pick the winning target once.
    always_comb begin
        redir     = trap_valid || br_valid;
        redir_tgt = trap_valid ? trap_target : br_target;
    end

    // Next-state, next-pc, counter and handshake decode.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_r;
        cnt_nxt   = cnt_r;
        mis_nxt   = mis_r;
        offer     = 1'b0;
        fire      = 1'b0;
        case (state)
            BOOT: begin
                state_nxt = RUN;
            end
            RUN: begin
                offer = !stall && !mis_r;
                fire  = offer && fetch.pc_ready;
                if (fire) begin
                    cnt_nxt = cnt_r + CNT_LEN'(1);
                end
                if (redir) begin
`ifdef YSYX_22041211_PC_ALIGN_CHECK_EN
                    if (redir_tgt[1:0] != 2'b00) begin
                        mis_nxt = 1'b1;
                    end else begin
                        pc_nxt  = redir_tgt;
                        mis_nxt = 1'b0;
                    end
`else
                    pc_nxt = redir_tgt & ~ADDR_LEN'(3);
`endif
                end else if (fire) begin
                    pc_nxt = pc_r + ADDR_LEN'(STEP);
                end
                if (halt) begin
                    state_nxt = HALT;
                end
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = BOOT;
            end
        endcase
    end

    // State, pc and fetch counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BOOT;
            pc_r  <= RESET_VAL;
            cnt_r <= '0;
        end else begin
            state <= state_nxt;
            pc_r  <= pc_nxt;
            cnt_r <= cnt_nxt;
        end
    end

`ifdef YSYX_22041211_PC_ALIGN_CHECK_EN
    // Sticky misaligned-redirect flag, cleared by reset or an aligned redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            mis_r <= 1'b0;
        end else begin
            mis_r <= mis_nxt;
        end
    end
`else
    assign mis_r = 1'b0;
`endif

    assign fetch.pc       = pc_r;
    assign fetch.pc_valid = offer;
    assign fetch_cnt      = cnt_r;
    assign pc_misalign    = mis_r;

endmodule
